ps2_host_cmd_ctrl: RTL and testbench
====================================

Name: ps2_host_cmd_ctrl

Overview:
Host-to-device command sequencer for the PS/2 keyboard port, e.g. LED set 0xED, reset 0xFF, typematic 0xF3. It takes one command byte and runs the full host-to-device frame on the open-drain PS/2 lines. It then waits for the device response byte from the existing receive path and retries on 0xFE (resend). It sits beside the keyboard receive driver; the top level ANDs its pull-low enables onto the shared psClk/psData pads.

Parameters:
INHIBIT_CYCLES, 5000, Clk cycles psClk is held low before request-to-send (100 us at 50 MHz).
CLK_TIMEOUT, 750000, max Clk cycles from RTS to the last line-ack edge (15 ms).
RESP_TIMEOUT, 1000000, max Clk cycles waiting for the response byte (20 ms).
MAX_RETRY, 3, resend attempts allowed after the first transmission.

Ports:
Clk  in  1  system clock, sole clock domain
Reset  in  1  synchronous, active-high reset
psClk_in  in  1  raw PS/2 clock pad level (asynchronous)
psData_in  in  1  raw PS/2 data pad level (asynchronous)
psClk_pull  out  1  1 = drive psClk pad low, 0 = release
psData_pull  out  1  1 = drive psData pad low, 0 = release
cmd_valid  in  1  command request
cmd_byte  in  8  command to send
cmd_ready  out  1  high in IDLE only; transfer occurs when cmd_valid&&cmd_ready
rx_valid  in  1  one-cycle strobe from receive path: new byte
rx_byte  in  8  received byte
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse: device answered 0xFA
err  out  1  one-cycle pulse: command failed
err_code  out  2  valid with err: 1 clock timeout, 2 no line ack, 3 retries exhausted, 3 also for response timeout is NOT used (response timeout = 1)

Behaviour:
- Reset is synchronous and active-high; all outputs are registered. Reset values: psClk_pull=0, psData_pull=0, cmd_ready=1, busy=0, done=0, err=0, err_code=0.
- Reset mid-operation returns to IDLE on the next edge, releases both lines, and clears the retry count.
- Input sync: psClk_in and psData_in each pass through 2 flops. A device-clock falling edge is detected when the synced previous value is 1 and the current value is 0, i.e. 3 Clk cycles after the pad edge.
- Frame: bit0..bit7 LSB first, then odd parity (parity = ~^byte), then the stop bit (released data).
- IDLE: cmd_ready=1. On handshake, latch byte, compute parity, set retry=0, go INHIBIT.
- INHIBIT: psClk_pull=1, psData_pull=0 for INHIBIT_CYCLES cycles, then RTS.
- RTS: psData_pull=1 (start bit), psClk_pull=0. Start CLK_TIMEOUT counter; go SHIFT with bit index 0.
- SHIFT: on each falling edge, present the next frame bit: psData_pull = ~bit. Edges 1-8 carry data bits, edge 9 parity, edge 10 stop (pull=0). On edge 11 go LINEACK.
- LINEACK: sample synced data on that same edge 11. Low means acked: go WAITRESP. High means err, code 2, go IDLE.
- CLK_TIMEOUT expiring before edge 11: release both lines, err code 1, go IDLE.
- WAITRESP: lines released; RESP_TIMEOUT counter running.
  - rx 0xFA: done pulse, go IDLE.
  - rx 0xFE: if retry<MAX_RETRY, retry++ and go INHIBIT with the same byte; otherwise err code 3.
  - Any other rx byte (scan code) is ignored and the counter keeps running.
  - Timeout: err code 1.
- cmd_valid while busy is ignored, with no queueing.
- done and err are never asserted together. Each is deasserted the cycle after its pulse.
- Falling edges seen in IDLE or WAITRESP are ignored.

Test Plan:
- Send 0xED; device model clocks 11 edges, pulls data low at edge 11, then sends 0xFA -> psData_pull pattern start 1, data bits ~{1,0,1,1,0,1,1,1}, parity bit 1 (pull 0), stop pull 0; single-cycle done; busy low after.
- Send 0xF3; device answers 0xFE, 0xFE, 0xFA -> three complete frames each preceded by ≥INHIBIT_CYCLES of psClk_pull=1; done once; no err.
- Send 0xFF; device always answers 0xFE -> 1+MAX_RETRY=4 frames, then err with err_code=3.
- Device never clocks after RTS -> err with err_code=1 exactly CLK_TIMEOUT cycles after RTS; both pulls 0 afterwards.
- Device leaves data high at edge 11 -> err, err_code=2; WAITRESP never entered (a later 0xFA gives no done).
- Assert Reset at edge 5 of SHIFT -> next cycle pulls=0, cmd_ready=1, busy=0; a new 0xED completes normally. A cmd_valid issued mid-frame is not accepted (cmd_ready=0).

Source files
------------

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, request-to-send, 11-bit frame, line ack, response wait with resend retry.
// All outputs registered; device clock edges are seen 3 Clk cycles after the pad edge. cmd_ready only in IDLE, no queueing.
module ps2_host_cmd_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int CLK_TIMEOUT    = 750000,
    parameter int RESP_TIMEOUT   = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       psClk_in,
    input  logic       psData_in,
    output logic       psClk_pull,
    output logic       psData_pull,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int M1 = (INHIBIT_CYCLES > CLK_TIMEOUT) ? INHIBIT_CYCLES : CLK_TIMEOUT;
    localparam int M2 = (M1 > RESP_TIMEOUT) ? M1 : RESP_TIMEOUT;
    localparam int CW = $clog2(M2 + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {S_IDLE, S_INHIBIT, S_SHIFT, S_WAITRESP} state_t;

    state_t          state_q;
    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      bit_idx_q;
    logic [7:0]      byte_q;
    logic            parity_q;
    logic [RW-1:0]   retry_q;
    logic            clk_pull_q, data_pull_q, ready_q, busy_q, done_q, err_q;
    logic [1:0]      err_code_q;
    logic            fall;

    assign fall        = clk_prev_q & ~clk_s2_q;
    assign psClk_pull  = clk_pull_q;
    assign psData_pull = data_pull_q;
    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_q      <= '0;
            parity_q    <= 1'b0;
            retry_q     <= '0;
            clk_pull_q  <= 1'b0;
            data_pull_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            clk_s1_q   <= psClk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= psData_in;
            dat_s2_q   <= dat_s1_q;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        byte_q     <= cmd_byte;
                        parity_q   <= ~^cmd_byte;
                        retry_q    <= '0;
                        cnt_q      <= '0;
                        clk_pull_q <= 1'b1;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                        // Request-to-send: release clock, start bit on data.
                        clk_pull_q  <= 1'b0;
                        data_pull_q <= 1'b1;
                        cnt_q       <= '0;
                        bit_idx_q   <= '0;
                        state_q     <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (fall) begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q < 4'd8) begin
                            data_pull_q <= ~byte_q[bit_idx_q[2:0]];
                        end else if (bit_idx_q == 4'd8) begin
                            data_pull_q <= ~parity_q;
                        end else if (bit_idx_q == 4'd9) begin
                            data_pull_q <= 1'b0;
                        end else if (!dat_s2_q) begin
                            cnt_q   <= '0;
                            state_q <= S_WAITRESP;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd2;
                            ready_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else if (cnt_q == CW'(CLK_TIMEOUT - 1)) begin
                        clk_pull_q  <= 1'b0;
                        data_pull_q <= 1'b0;
                        err_q       <= 1'b1;
                        err_code_q  <= 2'd1;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_WAITRESP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rx_valid && rx_byte == 8'hFA) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (rx_valid && rx_byte == 8'hFE) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q    <= retry_q + 1'b1;
                            cnt_q      <= '0;
                            clk_pull_q <= 1'b1;
                            state_q    <= S_INHIBIT;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd3;
                            ready_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else if (cnt_q == CW'(RESP_TIMEOUT - 1)) begin
                        // Scan codes from the keyboard do not restart the response window.
                        err_q      <= 1'b1;
                        err_code_q <= 2'd1;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: a PS/2 device model drives the clock, acks the line and answers with response bytes.
module tb_ps2_host_cmd_ctrl;
    localparam int INH  = 20;
    localparam int CTO  = 600;
    localparam int RTO  = 800;
    localparam int MR   = 3;
    localparam int HALF = 6;

    logic       Clk = 1'b0;
    logic       Reset, psClk_in, psData_in, psClk_pull, psData_pull;
    logic       cmd_valid, cmd_ready, rx_valid, busy, done, err;
    logic [7:0] cmd_byte, rx_byte;
    logic [1:0] err_code;

    int total = 0, bad = 0, cyc = 0;
    int done_seen = 0, err_seen = 0, both_seen = 0, wide_seen = 0;
    logic [1:0] last_code = 2'd0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    ps2_host_cmd_ctrl #(.INHIBIT_CYCLES(INH), .CLK_TIMEOUT(CTO), .RESP_TIMEOUT(RTO), .MAX_RETRY(MR)) dut (
        .Clk(Clk), .Reset(Reset), .psClk_in(psClk_in), .psData_in(psData_in),
        .psClk_pull(psClk_pull), .psData_pull(psData_pull),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc = cyc + 1;
        if (done === 1'b1) done_seen = done_seen + 1;
        if (err === 1'b1) begin
            err_seen  = err_seen + 1;
            last_code = err_code;
        end
        if (done === 1'b1 && err === 1'b1) both_seen = both_seen + 1;
        if ((prev_done && done === 1'b1) || (prev_err && err === 1'b1)) wide_seen = wide_seen + 1;
        prev_done = (done === 1'b1);
        prev_err  = (err === 1'b1);
    end

    function automatic logic exp_pull(input logic [7:0] b, input int k);
        if (k <= 8) return ~b[k-1];
        if (k == 9) return ($countones(b) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        @(negedge Clk);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_idle got=%b want=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_byte = b;
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%b want=1", busy); end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge Clk);
        rx_valid = 1'b1; rx_byte = b;
        @(negedge Clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_rts(output int inh, output bit ok);
        inh = 0; ok = 1'b0;
        for (int i = 0; i < INH + 200; i++) begin
            if (psClk_pull === 1'b0 && psData_pull === 1'b1) begin ok = 1'b1; break; end
            if (psClk_pull === 1'b1) inh++;
            @(negedge Clk);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit ack, input string tag);
        int inh; bit ok;
        wait_rts(inh, ok);
        total++;
        if (!ok || inh < INH || inh > INH + 2) begin
            bad++; $display("FAIL %s_inhibit rts=%0d cycles=%0d want>=%0d", tag, ok, inh, INH);
            return;
        end
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) psData_in = ack ? 1'b0 : 1'b1;
            psClk_in = 1'b0;
            repeat (HALF) @(negedge Clk);
            total++;
            if (psData_pull !== exp_pull(b, k) || psClk_pull !== 1'b0) begin
                bad++; $display("FAIL %s_edge%0d data_pull=%b clk_pull=%b want %b/0", tag, k, psData_pull, psClk_pull, exp_pull(b, k));
            end
            psClk_in = 1'b1;
            repeat (HALF) @(negedge Clk);
        end
        psData_in = 1'b1;
    endtask

    // Model: each 0xFE earns a retransmission until MAX_RETRY is spent; 0xFA ends with done.
    task automatic run_cmd_resp(input logic [7:0] b, input int n_fe, input int n_scan, input string tag);
        int frames, d0, e0;
        bit exp_done;
        logic [7:0] sc;
        frames   = ((n_fe > MR) ? MR : n_fe) + 1;
        exp_done = (n_fe <= MR);
        d0 = done_seen; e0 = err_seen;
        send_cmd(b);
        for (int f = 0; f < frames; f++) begin
            frame(b, 1'b1, tag);
            for (int s = 0; s < n_scan; s++) begin
                do sc = 8'($urandom_range(0, 255)); while (sc == 8'hFA || sc == 8'hFE);
                send_rx(sc);
            end
            send_rx((f < n_fe) ? 8'hFE : 8'hFA);
        end
        total++;
        if (done !== exp_done || err !== !exp_done) begin
            bad++; $display("FAIL %s_pulse done=%b err=%b want %b/%b", tag, done, err, exp_done, !exp_done);
        end
        repeat (4) @(negedge Clk);
        total++;
        if (done_seen - d0 != int'(exp_done) || err_seen - e0 != int'(!exp_done)) begin
            bad++; $display("FAIL %s_count done=%0d err=%0d want %0d/%0d", tag, done_seen - d0, err_seen - e0, exp_done, !exp_done);
        end
        if (!exp_done) begin
            total++;
            if (last_code !== 2'd3) begin bad++; $display("FAIL %s_code got=%0d want=3", tag, last_code); end
        end
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || psClk_pull !== 1'b0 || psData_pull !== 1'b0) begin
            bad++; $display("FAIL %s_idle busy=%b ready=%b pulls=%b%b want 0/1/00", tag, busy, cmd_ready, psClk_pull, psData_pull);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        total++;
        if (psClk_pull !== 1'b0 || psData_pull !== 1'b0) begin bad++; $display("FAIL reset_pulls got=%b%b want=00", psClk_pull, psData_pull); end
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_ready_busy got=%b%b want=10", cmd_ready, busy); end
        total++;
        if (done !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL reset_status got=%b%b%0d want=000", done, err, err_code); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_led();
        run_cmd_resp(8'hED, 0, 0, "led");
    endtask

    task automatic test_resend();
        run_cmd_resp(8'hF3, 2, 0, "resend");
        run_cmd_resp(8'hFF, 9, 0, "exhaust");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_cmd_resp(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 2), "rand");
    endtask

    task automatic test_clk_timeout();
        int inh, c0, e0; bit ok;
        e0 = err_seen;
        send_cmd(8'hF4);
        wait_rts(inh, ok);
        c0 = cyc;
        for (int i = 0; i < CTO + 50; i++) begin
            if (err === 1'b1) break;
            @(negedge Clk);
        end
        total++;
        if (err !== 1'b1 || cyc - c0 != CTO) begin bad++; $display("FAIL clkto_time err=%b cycles=%0d want=%0d", err, cyc - c0, CTO); end
        total++;
        if (err_code !== 2'd1) begin bad++; $display("FAIL clkto_code got=%0d want=1", err_code); end
        @(negedge Clk);
        total++;
        if (psClk_pull !== 1'b0 || psData_pull !== 1'b0 || busy !== 1'b0 || err_seen - e0 != 1) begin
            bad++; $display("FAIL clkto_after pulls=%b%b busy=%b errs=%0d want 00/0/1", psClk_pull, psData_pull, busy, err_seen - e0);
        end
    endtask

    task automatic test_resp_timeout();
        int t;
        send_cmd(8'hF2);
        frame(8'hF2, 1'b1, "rspto");
        t = 0;
        while (err !== 1'b1 && t < RTO + 50) begin @(negedge Clk); t++; end
        total++;
        if (err !== 1'b1 || err_code !== 2'd1 || t > RTO) begin bad++; $display("FAIL rspto err=%b code=%0d wait=%0d want 1/1/<=%0d", err, err_code, t, RTO); end
        @(negedge Clk);
    endtask

    task automatic test_nack();
        int d0, e0;
        d0 = done_seen; e0 = err_seen;
        send_cmd(8'h55);
        frame(8'h55, 1'b0, "nack");
        repeat (3) @(negedge Clk);
        total++;
        if (err_seen - e0 != 1 || last_code !== 2'd2 || busy !== 1'b0) begin
            bad++; $display("FAIL nack_err errs=%0d code=%0d busy=%b want 1/2/0", err_seen - e0, last_code, busy);
        end
        send_rx(8'hFA);
        repeat (3) @(negedge Clk);
        total++;
        if (done_seen - d0 != 0) begin bad++; $display("FAIL nack_nodone dones=%0d want=0", done_seen - d0); end
    endtask

    task automatic test_reset_mid();
        int inh; bit ok;
        send_cmd(8'hED);
        wait_rts(inh, ok);
        for (int k = 1; k <= 5; k++) begin
            psClk_in = 1'b0;
            repeat (HALF) @(negedge Clk);
            if (k == 3) begin
                total++;
                if (cmd_ready !== 1'b0) begin bad++; $display("FAIL midcmd_ready got=%b want=0", cmd_ready); end
                cmd_valid = 1'b1; cmd_byte = 8'h00;
                @(negedge Clk);
                cmd_valid = 1'b0;
            end
            if (k == 4) begin
                total++;
                if (psData_pull !== exp_pull(8'hED, 4)) begin bad++; $display("FAIL midcmd_edge4 got=%b want=%b", psData_pull, exp_pull(8'hED, 4)); end
            end
            if (k == 5) begin
                Reset = 1'b1;
                @(negedge Clk);
                Reset = 1'b0;
                total++;
                if (psClk_pull !== 1'b0 || psData_pull !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                    bad++; $display("FAIL midreset pulls=%b%b ready=%b busy=%b want 00/1/0", psClk_pull, psData_pull, cmd_ready, busy);
                end
            end
            psClk_in = 1'b1;
            repeat (HALF) @(negedge Clk);
        end
        run_cmd_resp(8'hED, 0, 0, "postreset");
    endtask

    task automatic test_pulses();
        total++;
        if (both_seen != 0 || wide_seen != 0) begin bad++; $display("FAIL pulse_shape both=%0d wide=%0d want 0/0", both_seen, wide_seen); end
    endtask

    initial begin
        Reset = 1'b1; psClk_in = 1'b1; psData_in = 1'b1;
        cmd_valid = 1'b0; cmd_byte = 8'h00; rx_valid = 1'b0; rx_byte = 8'h00;
        test_reset();
        test_led();
        test_resend();
        test_random();
        test_clk_timeout();
        test_resp_timeout();
        test_nack();
        test_reset_mid();
        test_pulses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
